// File: rtl/ula_sequencer.sv
// ula_sequencer: control unit for the 4-bit ULA datapath (registers X, Y, Z).
// Accepts one instruction per valid/ready handshake. Each instruction becomes
// per-cycle register codes and ULA controls. All outputs are Moore outputs.
// Ports:
//   clock        system clock, rising edge
//   rst_n        asynchronous active-low reset
//   instr_valid  instruction present
//   instr_ready  high only in IDLE
//   opcode       instruction opcode (0 NOP .. 11 ACCADD, 12..15 illegal)
//   count        extra ACCADD iterations
//   tx, ty, tz   X/Y/Z register control codes (CLEAR/LOAD/HOLD)
//   ula_op       ULA operation select
//   sel_x        X input mux: 0 external operand, 1 Z feedback
//   done         one-cycle completion pulse
//   err          pulses with done for an illegal opcode
module ula_sequencer #(
  parameter logic [3:0] CODE_CLEAR = 4'd0,
  parameter logic [3:0] CODE_LOAD  = 4'd1,
  parameter logic [3:0] CODE_HOLD  = 4'd2,
  parameter int         CNT_W      = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       opcode,
  input  logic [CNT_W-1:0] count,
  output logic [3:0]       tx,
  output logic [3:0]       ty,
  output logic [3:0]       tz,
  output logic [2:0]       ula_op,
  output logic             sel_x,
  output logic             done,
  output logic             err
);
  localparam logic [3:0] OP_CLR = 4'd1, OP_LDX = 4'd2, OP_LDY = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4, OP_NOT = 4'd9, OP_MOV = 4'd10, OP_ACC = 4'd11;
  typedef enum logic [3:0] {IDLE, CLR, LDX, LDY, MOV, EXEC, WRITE, FEED, DONE} state_t;
  state_t state, state_n, dispatch;
  logic [3:0] op;
  logic [CNT_W-1:0] iter;
  logic accept;
  logic [2:0] alu_code;
  assign accept = instr_valid & instr_ready;
  // ACCADD always adds; the plain ALU opcodes map 4..9 onto selects 0..5
  assign alu_code = (op == OP_ACC) ? 3'd0 : 3'(op - OP_ADD);
  always_comb begin
    dispatch = DONE;
    if (opcode == OP_CLR) dispatch = CLR;
    else if (opcode == OP_LDX) dispatch = LDX;
    else if (opcode == OP_LDY) dispatch = LDY;
    else if (opcode == OP_MOV) dispatch = MOV;
    else if ((opcode >= OP_ADD && opcode <= OP_NOT) || opcode == OP_ACC) dispatch = EXEC;
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= '0;
      iter  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op   <= opcode;
        iter <= (opcode == OP_ACC) ? count : '0;
      end else if (state == FEED) begin
        iter <= iter - 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:              state_n = accept ? dispatch : IDLE;
      CLR, LDX, LDY, MOV: state_n = DONE;
      EXEC:              state_n = WRITE;
      // FEED is only entered with iter != 0, so iter never wraps below zero
      WRITE:             state_n = (op == OP_ACC && iter != '0) ? FEED : DONE;
      FEED:              state_n = EXEC;
      DONE:              state_n = IDLE;
      default:           state_n = IDLE;
    endcase
  end
  always_comb begin
    tx          = CODE_HOLD;
    ty          = CODE_HOLD;
    tz          = CODE_HOLD;
    ula_op      = 3'd0;
    sel_x       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    instr_ready = 1'b0;
    unique case (state)
      IDLE: instr_ready = 1'b1;
      CLR: begin
        tx = CODE_CLEAR;
        ty = CODE_CLEAR;
        tz = CODE_CLEAR;
      end
      LDX: tx = CODE_LOAD;
      LDY: ty = CODE_LOAD;
      MOV: begin
        tx    = CODE_LOAD;
        sel_x = 1'b1;
      end
      EXEC: ula_op = alu_code;
      WRITE: begin
        ula_op = alu_code;
        tz     = CODE_LOAD;
      end
      FEED: begin
        ula_op = alu_code;
        tx     = CODE_LOAD;
        sel_x  = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        err  = op >= 4'd12;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ula_sequencer.sv
// tb_ula_sequencer: scoreboard bench for ula_sequencer with a small X/Y/Z datapath model.
module tb_ula_sequencer;
  localparam logic [3:0] C = 4'd0, L = 4'd1, H = 4'd2;
  logic clock = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, instr_ready;
  logic [3:0] opcode = '0, count = '0, tx, ty, tz;
  logic [2:0] ula_op;
  logic sel_x, done, err;
  logic [3:0] ext_x = '0, ext_y = '0, x_m, y_m, z_m;
  logic [17:0] sb[$];
  int checks = 0, fails = 0;
  localparam logic [17:0] IDLE_V = {H, H, H, 3'd0, 1'b0, 1'b0, 1'b0};

  ula_sequencer dut (
    .clock(clock), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .count(count), .tx(tx), .ty(ty), .tz(tz), .ula_op(ula_op),
    .sel_x(sel_x), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] alu(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      x_m <= '0;
      y_m <= '0;
      z_m <= '0;
    end else begin
      if (tx == C) x_m <= '0; else if (tx == L) x_m <= sel_x ? z_m : ext_x;
      if (ty == C) y_m <= '0; else if (ty == L) y_m <= ext_y;
      if (tz == C) z_m <= '0; else if (tz == L) z_m <= alu(ula_op, x_m, y_m);
    end
  end

  function automatic logic [17:0] v(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                    input logic [2:0] o, input logic s, input logic d, input logic e);
    return {a, b, c, o, s, d, e};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] o, input logic [3:0] c);
    logic [2:0] a;
    a = (o == 4'd11) ? 3'd0 : 3'(o - 4'd4);
    case (o)
      4'd0: ;
      4'd1: sb.push_back(v(C, C, C, 0, 0, 0, 0));
      4'd2: sb.push_back(v(L, H, H, 0, 0, 0, 0));
      4'd3: sb.push_back(v(H, L, H, 0, 0, 0, 0));
      4'd10: sb.push_back(v(L, H, H, 0, 1, 0, 0));
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11: begin
        sb.push_back(v(H, H, H, a, 0, 0, 0));
        sb.push_back(v(H, H, L, a, 0, 0, 0));
        if (o == 4'd11)
          for (int i = 0; i < int'(c); i++) begin
            sb.push_back(v(L, H, H, 0, 1, 0, 0));
            sb.push_back(v(H, H, H, 0, 0, 0, 0));
            sb.push_back(v(H, H, L, 0, 0, 0, 0));
          end
      end
      default: ;
    endcase
    sb.push_back(v(H, H, H, 0, 0, 1, o >= 4'd12));
  endtask

  always @(negedge clock) begin
    logic [17:0] cur;
    cur = {tx, ty, tz, ula_op, sel_x, done, err};
    if (rst_n) begin
      if (!instr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_busy act=%0h exp=idle t=%0t", cur, $time);
        end else chk("trace", 32'(cur), 32'(sb.pop_front()));
      end else begin
        if (sb.size() != 0) begin
          checks++;
          fails++;
          $display("FAIL early_idle act=idle exp=%0d_more_cycles t=%0t", sb.size(), $time);
          sb.delete();
        end
        chk("idle", 32'(cur), 32'(IDLE_V));
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [3:0] c);
    int n = 0;
    @(negedge clock);
    while (!instr_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout act=busy exp=ready op=%0d", o);
    end
    instr_valid = 1'b1;
    opcode = o;
    count = c;
    @(posedge clock);
    push_exp(o, c);
  endtask

  task automatic finish_instr();
    int n = 0;
    @(negedge clock);
    instr_valid = 1'b0;
    while (!(instr_ready && sb.size() == 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout act=busy exp=ready");
    end
  endtask

  initial begin
    #12;
    chk("reset_out", 32'({instr_ready, tx, ty, tz, ula_op, sel_x, done, err}), 32'({1'b1, IDLE_V}));
    @(negedge clock);
    #2 rst_n = 1'b1;
    ext_x = 4'd3;
    ext_y = 4'd5;
    send(4'd2, 4'd0);
    send(4'd3, 4'd0);
    send(4'd4, 4'd9);
    finish_instr();
    chk("add_z", 32'(z_m), 32'd8);
    chk("add_x", 32'(x_m), 32'd3);
    send(4'd1, 4'd0);
    finish_instr();
    chk("clr_xyz", 32'({x_m, y_m, z_m}), 32'h000);
    ext_x = 4'd1;
    ext_y = 4'd2;
    send(4'd2, 4'd0);
    send(4'd3, 4'd0);
    send(4'd11, 4'd2);
    finish_instr();
    chk("acc2_z", 32'(z_m), 32'd7);
    send(4'd13, 4'd5);
    send(4'd9, 4'd0);
    finish_instr();
    chk("not_z", 32'(z_m), 32'hA);
    send(4'd2, 4'd0);
    send(4'd11, 4'd0);
    finish_instr();
    chk("acc0_z", 32'(z_m), 32'd3);
    send(4'd4, 4'd7);
    finish_instr();
    chk("add_cnt_ignored_z", 32'(z_m), 32'd3);
    ext_y = 4'd1;
    send(4'd3, 4'd0);
    send(4'd11, 4'd15);
    finish_instr();
    chk("acc15_z", 32'(z_m), 32'd1);
    ext_x = 4'd9;
    ext_y = 4'd4;
    send(4'd2, 4'd0);
    send(4'd3, 4'd0);
    send(4'd5, 4'd0);
    send(4'd10, 4'd0);
    send(4'd0, 4'd0);
    finish_instr();
    chk("b2b_z", 32'(z_m), 32'd5);
    chk("b2b_x", 32'(x_m), 32'd5);
    send(4'd11, 4'd3);
    repeat (4) @(negedge clock);
    #2 rst_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("async_reset_out", 32'({instr_ready, tx, ty, tz, ula_op, sel_x, done, err}), 32'({1'b1, IDLE_V}));
    sb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 rst_n = 1'b1;
    ext_x = 4'd2;
    ext_y = 4'd6;
    send(4'd2, 4'd0);
    send(4'd3, 4'd0);
    send(4'd4, 4'd0);
    finish_instr();
    chk("post_reset_z", 32'(z_m), 32'd8);
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
- Control unit for the 4-bit ULA datapath: registers X, Y and Z plus the ULA between them.
- Accepts one instruction at a time over a valid/ready handshake.
- Decodes it into per-cycle control codes for the X, Y and Z registers (tx, ty, tz), the ULA operation select and the X-input mux.
- Supports single operations and a repeated accumulate loop (Z fed back into X).

Parameters:
- CODE_CLEAR, 4'd0, register control code: clear
- CODE_LOAD, 4'd1, register control code: load
- CODE_HOLD, 4'd2, register control code: hold
- CNT_W, 4, width of the repeat-count field

Ports:
- clock  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction present
- instr_ready  output  1  sequencer can accept an instruction
- opcode  input  4  instruction opcode
- count  input  CNT_W  extra iterations for ACCADD (ignored otherwise)
- tx  output  4  X register control code
- ty  output  4  Y register control code
- tz  output  4  Z register control code
- ula_op  output  3  ULA operation select
- sel_x  output  1  X input mux: 0 = external operand, 1 = Z feedback
- done  output  1  one-cycle pulse, instruction complete
- err  output  1  one-cycle pulse with done, illegal opcode

Behaviour:
- Reset is asynchronous and active-low: clock is the single clock; rst_n asserted low forces the state to IDLE immediately, with no clock edge required.
- Reset values:
  - instr_ready = 1 (IDLE)
  - tx = ty = tz = CODE_HOLD
  - ula_op = 0, sel_x = 0, done = 0, err = 0
  - iteration counter = 0
- Reset mid-instruction abandons the instruction; no done is produced.
- All outputs are decoded from registered state (Moore). Defaults in every state are t* = HOLD and sel_x = 0.
- Handshake: instr_ready = 1 only in IDLE. On a rising edge with instr_valid & instr_ready, opcode and count are captured. instr_valid while busy is ignored.
- Opcode map:
  - 0 NOP
  - 1 CLR
  - 2 LDX
  - 3 LDY
  - 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 NOT (ula_op = opcode - 4, i.e. 0..5)
  - 10 MOV (Z to X)
  - 11 ACCADD
  - 12..15 illegal
- States and transitions:
  - IDLE: waits for the handshake, then goes to the decoded state.
  - NOP: goes directly to DONE.
  - Illegal opcode: goes to DONE with err latched.
  - CLR: 1 cycle, tx = ty = tz = CLEAR, then DONE.
  - LDX: tx = LOAD, sel_x = 0, then DONE.
  - LDY: ty = LOAD, then DONE.
  - MOV: tx = LOAD, sel_x = 1, then DONE.
  - EXEC: ula_op driven, all registers HOLD (operand settle cycle), then WRITE.
  - WRITE: ula_op held, tz = LOAD. Next is FEED if the opcode is ACCADD and iter != 0; otherwise DONE.
  - FEED: tx = LOAD, sel_x = 1, ula_op held, iter decrements, then EXEC.
  - DONE: done = 1 (err = 1 if illegal), then IDLE.
- ACCADD: ula_op = 0 (ADD); iter loads count at acceptance; the loop executes count+1 additions.
- Latency, counting cycles after the acceptance edge:
  - NOP/illegal: done in cycle 1.
  - CLR/LDX/LDY/MOV: action in cycle 1, done in cycle 2.
  - ALU op: EXEC in cycle 1, WRITE in cycle 2, done in cycle 3.
  - ACCADD with count = n: done in cycle 3n+3.
- Boundaries:
  - count = 0 on ACCADD behaves exactly like ADD.
  - count = 2^CNT_W - 1 runs 2^CNT_W iterations with no wrap of iter below 0.
  - count is ignored for non-ACC opcodes.
  - A new instruction may be accepted in the cycle after done (IDLE); the handshake-to-handshake minimum is 2 cycles.

Test Plan:
- Reset held low mid-ACCADD (cycle 4), then released → outputs immediately at HOLD/0, instr_ready = 1, no done pulse; the next instruction is accepted normally.
- LDX then LDY then ADD, with external X = 4'd3 and Y = 4'd5 → tx = LOAD/sel_x = 0 one cycle; ty = LOAD one cycle; ADD gives EXEC (ula_op = 0), WRITE (tz = LOAD), done on cycle 3; Z = 4'd8.
- CLR → tx = ty = tz = CODE_CLEAR for exactly one cycle, done in cycle 2; X = Y = Z = 0.
- ACCADD with count = 2, X = 1, Y = 2 → sequence EXEC, WRITE, FEED, EXEC, WRITE, FEED, EXEC, WRITE, DONE; done at cycle 9; Z = 4'd7; instr_ready low throughout.
- Opcode 4'd13 → done and err together at cycle 1, no t* code other than HOLD; then opcode 9 (NOT) gives ula_op = 5 and done at cycle 3.
- instr_valid held high with back-to-back opcodes → each is accepted only when instr_ready = 1; the second is captured the cycle after done; no instruction is dropped or duplicated.
